// File: rtl/pwr_event_ctrl.sv
// rtl/pwr_event_ctrl.sv - power-button front end and PSU on/off sequencer on the suspend clock
module pwr_event_ctrl #(
    parameter int DEBOUNCE_CYC = 660,
    parameter int OVERRIDE_CYC = 131072,
    parameter int PSOK_TMO_CYC = 32768,
    parameter int MIN_OFF_CYC  = 165
) (
    input  logic       CLK_33K_SUSCLK_PLD_R2,
    input  logic       RST_RSMRST_N,
    input  logic       FP_PWR_BTN_N,
    input  logic       FM_BMC_PWRBTN_OUT_N,
    input  logic       PWRGD_PS_PWROK_3V3,
    input  logic       FM_SLPS3_N,
    input  logic       FM_THERMTRIP_CO_N,
    output logic       PsonFromPwrEvent,
    output logic       FM_PCH_PWRBTN_N,
    output logic [1:0] PwrEvtState
);

    localparam int DBW     = $clog2(DEBOUNCE_CYC + 1);
    localparam int OVW     = $clog2(OVERRIDE_CYC + 1);
    localparam int TMR_MAX = (PSOK_TMO_CYC > MIN_OFF_CYC) ? PSOK_TMO_CYC : MIN_OFF_CYC;
    localparam int TMW     = $clog2(TMR_MAX + 1);

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [OVW-1:0] OVR_FULL = OVW'(OVERRIDE_CYC);
    localparam logic [TMW-1:0] TMO_LAST = TMW'(PSOK_TMO_CYC - 1);
    localparam logic [TMW-1:0] MIN_LAST = TMW'(MIN_OFF_CYC - 1);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_PS_WAIT  = 2'd1,
        ST_ON       = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    // bit order: 0 fp button, 1 bmc button, 2 pwrok, 3 slps3_n, 4 thermtrip_n
    logic [4:0] raw_in;
    logic [4:0] meta_q;
    logic [4:0] sync_q;

    logic [1:0]          db_q;
    logic [1:0][DBW-1:0] db_cnt_q;

    logic           btn;
    logic           btn_q;
    logic           press_q;
    logic [OVW-1:0] held_q;
    logic [OVW-1:0] held_d;

    state_e         state_q;
    state_e         state_d;
    logic [TMW-1:0] tmr_q;
    logic [TMW-1:0] tmr_d;
    logic           pson_q;
    logic           pch_q;

    logic pwrok_s;
    logic slps3_s;
    logic therm_ok_s;

    assign raw_in     = {FM_THERMTRIP_CO_N, FM_SLPS3_N, PWRGD_PS_PWROK_3V3,
                         FM_BMC_PWRBTN_OUT_N, FP_PWR_BTN_N};
    assign pwrok_s    = sync_q[2];
    assign slps3_s    = sync_q[3];
    assign therm_ok_s = sync_q[4];

    // Two-flop synchronisers; idle-high so release from reset looks like "nothing pressed"
    always_ff @(posedge CLK_33K_SUSCLK_PLD_R2 or negedge RST_RSMRST_N) begin
        if (!RST_RSMRST_N) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= raw_in;
            sync_q <= meta_q;
        end
    end

    // Per-button debounce: accept a new level after DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge CLK_33K_SUSCLK_PLD_R2 or negedge RST_RSMRST_N) begin
        if (!RST_RSMRST_N) begin
            db_q     <= '1;
            db_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_q[i]     <= ~db_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign btn = &db_q;

    // Consecutive low-cycle count of the combined button, saturating for the override
    always_comb begin
        held_d = held_q;
        if (btn) begin
            held_d = '0;
        end else if (held_q != OVR_FULL) begin
            held_d = held_q + 1'b1;
        end
    end

    // Falling-edge detect of the combined button and override hold counter
    always_ff @(posedge CLK_33K_SUSCLK_PLD_R2 or negedge RST_RSMRST_N) begin
        if (!RST_RSMRST_N) begin
            btn_q   <= 1'b1;
            press_q <= 1'b0;
            held_q  <= '0;
        end else begin
            btn_q   <= btn;
            press_q <= btn_q & ~btn;
            held_q  <= held_d;
        end
    end

    // Next-state and shared timer; thermtrip always wins, every fault path lands in COOLDOWN
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_OFF: begin
                if (press_q && therm_ok_s) begin
                    state_d = ST_PS_WAIT;
                    tmr_d   = '0;
                end
            end
            ST_PS_WAIT: begin
                if (!therm_ok_s) begin
                    state_d = ST_COOLDOWN;
                    tmr_d   = '0;
                end else if (pwrok_s) begin
                    state_d = ST_ON;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = ST_COOLDOWN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_ON: begin
                if (!therm_ok_s || !pwrok_s || !slps3_s || (held_d == OVR_FULL)) begin
                    state_d = ST_COOLDOWN;
                    tmr_d   = '0;
                end
            end
            ST_COOLDOWN: begin
                if (tmr_q == MIN_LAST) begin
                    if (btn) begin
                        state_d = ST_OFF;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
                tmr_d   = '0;
            end
        endcase
    end

    // FSM registers; outputs are registered from the next state so they move with the state
    always_ff @(posedge CLK_33K_SUSCLK_PLD_R2 or negedge RST_RSMRST_N) begin
        if (!RST_RSMRST_N) begin
            state_q <= ST_OFF;
            tmr_q   <= '0;
            pson_q  <= 1'b0;
            pch_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pson_q  <= (state_d == ST_PS_WAIT) || (state_d == ST_ON);
            pch_q   <= (state_d == ST_COOLDOWN) ? 1'b1 : btn;
        end
    end

    assign PsonFromPwrEvent = pson_q;
    assign FM_PCH_PWRBTN_N  = pch_q;
    assign PwrEvtState      = state_q;

endmodule
